stream_width_upsizer: RTL and testbench
=======================================

# stream_width_upsizer

Packs a narrow valid/ready byte stream into wide words, with framing by an input last flag. It sits directly downstream of skid_buffer and consumes its out_data/out_valid/out_ready port, presenting a wide stream with per-lane keep. Partial words are flushed on in_last. Both ports follow AXI-Stream handshake rules.

## Interface
- IN_WIDTH, default 8: input beat width in bits.
- RATIO, default 4: input beats per output word; legal range 2 to 16.
- OUT_WIDTH, default IN_WIDTH*RATIO: derived; must not be overridden.
- clk  input  1  single clock; all logic on rising edge.
- resetn  input  1  synchronous, active-low reset.
- in_data  input  IN_WIDTH  input beat.
- in_last  input  1  beat ends a frame.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block accepts a beat.
- out_data  output  OUT_WIDTH  packed word; lane k is bits [k*IN_WIDTH +: IN_WIDTH].
- out_keep  output  RATIO  lane k holds valid data.
- out_last  output  1  word ends a frame.
- out_valid  output  1  word valid.
- out_ready  input  1  downstream accepts the word.

## Operation
- State:
  - accumulator acc_data[OUT_WIDTH] and acc_keep[RATIO];
  - lane counter lane of width $clog2(RATIO), range 0..RATIO-1;
  - acc_last flag;
  - pending flag;
  - output register out_*.
- A beat is accepted when in_valid && in_ready.
  - It is written into lane `lane`, and acc_keep[lane] is set.
  - Lane 0 is the first beat (little-endian packing).
- The completing beat is one where lane==RATIO-1 or in_last==1.
  - If the output register is free (!out_valid || out_ready), the packed word moves straight into out_*.
  - Otherwise it stays in the accumulator and pending is set.
- After completion, lane returns to 0.
- On every output handshake while pending==1, the accumulator moves into out_* and pending clears.
- Lanes that were never written are output as all-zero data with keep=0. Keep is always contiguous from lane 0.
- in_ready = resetn && !pending. It depends only on registered state, with no combinational path from out_ready.
- A word is never split, duplicated, or dropped; data order is preserved.

## Timing
- Reset (resetn low at an edge):
  - out_valid=0, out_data=0, out_keep=0, out_last=0;
  - lane=0, pending=0, accumulator cleared;
  - in_ready=0 while resetn is low.
- Reset mid-frame discards the partial word, and any word held in the output register.
- Latency: out_valid rises the cycle after the completing beat is accepted.
- Throughput: with out_ready held high, one input beat is accepted every cycle with no bubbles. One word is produced every RATIO cycles, or earlier on in_last.
- Completion in the same cycle as an output handshake loads out_* directly, with no pending and no bubble.
- Completion while out_valid && !out_ready:
  - pending=1 and in_ready=0 from the next cycle;
  - after the output handshake, out_* reloads on the following edge and in_ready returns to 1 in that same cycle.
- Once asserted, out_valid stays high and out_data/out_keep/out_last stay stable until handshake.
- in_last with lane==RATIO-1 is a normal full word with out_last=1.
- in_last on lane 0 gives a single-lane word with keep=0b0001.

## Structure
- Shared stream package holds:
  - a lane-count width helper function (clog2-based);
  - a RATIO legality check constant used by an elaboration-time assertion.
- No sub-module: the accumulator and output register are inline.
- Formal harness stream_width_upsizer_tb_formal:
  - binds axi_stream_slave_monitor on the input and axi_stream_master_monitor on the output;
  - asserts beats-in minus words-out never exceeds 2*RATIO.

## Test plan
- Reset: hold resetn low 3 cycles while driving traffic -> in_ready=0, out_valid=0, out_keep=0; first beat accepted on the cycle after resetn rises.
- Full rate: out_ready=1, bytes 0x11,0x22,0x33,0x44 (last on 0x44) on consecutive cycles -> the cycle after 0x44 is accepted, out_data=0x44332211, out_keep=0xF, out_last=1; in_ready never drops.
- Short frame: 0xAA,0xBB with last on 0xBB -> out_data=0x0000BBAA, keep=0x3, last=1; the next frame starts at lane 0.
- Backpressure: out_ready=0 and two full words sent -> first word held stable; second word completes, pending=1, in_ready=0. Raising out_ready for 1 cycle shows the second word on the next cycle and in_ready=1.
- Same-cycle event: the completing beat of word 2 is accepted in the same cycle as word 1's handshake -> word 2 appears next cycle, pending stays 0.
- Mid-frame reset after 2 beats -> no output word; the next frame packs from lane 0 with the correct keep.

Source files
------------

// File: rtl/stream_width_upsizer_pkg.sv
// Shared stream helpers: lane-index sizing and the legal range for upsizer ratios.
package stream_width_upsizer_pkg;

    localparam int unsigned RATIO_MIN = 2;
    localparam int unsigned RATIO_MAX = 16;

    function automatic bit ratio_legal(int unsigned ratio);
        return (ratio >= RATIO_MIN) && (ratio <= RATIO_MAX);
    endfunction

    // A lane index needs at least one bit even for a degenerate ratio.
    function automatic int unsigned lane_width(int unsigned ratio);
        return (ratio < 2) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/stream_width_upsizer.sv
// Packs narrow valid/ready beats little-endian into RATIO-lane words with per-lane keep;
// a partial word is flushed when in_last is seen.
module stream_width_upsizer
    import stream_width_upsizer_pkg::*;
#(
    parameter int IN_WIDTH  = 8,
    parameter int RATIO     = 4,
    parameter int OUT_WIDTH = IN_WIDTH * RATIO
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_last,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [RATIO-1:0]     out_keep,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int LW = lane_width(RATIO);
    localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

    if (!ratio_legal(RATIO)) begin : g_bad_ratio
        $error("stream_width_upsizer: RATIO must lie in 2..16");
    end
    if (OUT_WIDTH != IN_WIDTH * RATIO) begin : g_bad_out_width
        $error("stream_width_upsizer: OUT_WIDTH must equal IN_WIDTH*RATIO");
    end

    logic [OUT_WIDTH-1:0] acc_data_q, acc_data_d;
    logic [RATIO-1:0]     acc_keep_q, acc_keep_d;
    logic                 acc_last_q, acc_last_d;
    logic [LW-1:0]        lane_q, lane_d;
    logic                 pending_q, pending_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic [RATIO-1:0]     out_keep_q, out_keep_d;
    logic                 out_last_q, out_last_d;
    logic                 out_valid_q, out_valid_d;

    logic                 accept;
    logic                 complete;
    logic                 out_free;
    logic [OUT_WIDTH-1:0] packed_data;
    logic [RATIO-1:0]     packed_keep;

    // Ready comes only from registered state, so no out_ready -> in_ready path exists.
    assign in_ready = resetn && !pending_q;
    assign accept   = in_valid && in_ready;
    assign complete = accept && ((lane_q == LAST_LANE) || in_last);
    assign out_free = !out_valid_q || out_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned,
        // which is what would otherwise infer a latch; blocking '=' is correct in here.
        acc_data_d  = acc_data_q;
        acc_keep_d  = acc_keep_q;
        acc_last_d  = acc_last_q;
        lane_d      = lane_q;
        pending_d   = pending_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        packed_data = acc_data_q;
        packed_data[lane_q*IN_WIDTH +: IN_WIDTH] = in_data;
        packed_keep = acc_keep_q;
        packed_keep[lane_q] = 1'b1;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // A held word drains on handshake; in_ready is low then, so no beat competes.
        if (pending_q && out_ready) begin
            out_data_d  = acc_data_q;
            out_keep_d  = acc_keep_q;
            out_last_d  = acc_last_q;
            out_valid_d = 1'b1;
            pending_d   = 1'b0;
            acc_data_d  = '0;
            acc_keep_d  = '0;
            acc_last_d  = 1'b0;
        end

        if (accept) begin
            if (complete) begin
                lane_d = '0;
                if (out_free) begin
                    out_data_d  = packed_data;
                    out_keep_d  = packed_keep;
                    out_last_d  = in_last;
                    out_valid_d = 1'b1;
                    acc_data_d  = '0;
                    acc_keep_d  = '0;
                    acc_last_d  = 1'b0;
                end else begin
                    acc_data_d = packed_data;
                    acc_keep_d = packed_keep;
                    acc_last_d = in_last;
                    pending_d  = 1'b1;
                end
            end else begin
                acc_data_d = packed_data;
                acc_keep_d = packed_keep;
                lane_d     = lane_q + LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            // NOTE: the accumulator is cleared on reset because unwritten lanes must read
            // back as zero; a partial word from before reset must never leak out.
            acc_data_q  <= '0;
            acc_keep_q  <= '0;
            acc_last_q  <= 1'b0;
            lane_q      <= '0;
            pending_q   <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_data_q  <= acc_data_d;
            acc_keep_q  <= acc_keep_d;
            acc_last_q  <= acc_last_d;
            lane_q      <= lane_d;
            pending_q   <= pending_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_width_upsizer.sv
// Directed bench for stream_width_upsizer at IN_WIDTH=8, RATIO=4 with hand-computed words.
module tb_stream_width_upsizer;

    logic        clk;
    logic        resetn;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    int total = 0;
    int bad   = 0;

    stream_width_upsizer #(.IN_WIDTH(8), .RATIO(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic l);
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        #1;
        check("beat_in_ready", 32'(in_ready), 32'h1);
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
    endtask

    initial begin
        resetn    = 1'b0;
        in_data   = 8'h55;
        in_last   = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;

        // Reset held for 3 edges with traffic present.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_in_ready",  32'(in_ready),  32'h0);
            check("rst_out_valid", 32'(out_valid), 32'h0);
            check("rst_out_keep",  32'(out_keep),  32'h0);
        end
        check("rst_out_data", out_data, 32'h0);

        // Full rate: first beat is taken on the edge after resetn rises.
        resetn = 1'b1;
        beat(8'h11, 1'b0);
        check("fr_no_early_valid", 32'(out_valid), 32'h0);
        beat(8'h22, 1'b0);
        beat(8'h33, 1'b0);
        check("fr_still_empty", 32'(out_valid), 32'h0);
        beat(8'h44, 1'b1);
        check("fr_valid", 32'(out_valid), 32'h1);
        check("fr_data",  out_data,        32'h44332211);
        check("fr_keep",  32'(out_keep),   32'hF);
        check("fr_last",  32'(out_last),   32'h1);

        // Short frame follows back to back.
        beat(8'hAA, 1'b0);
        check("fr_drained", 32'(out_valid), 32'h0);
        beat(8'hBB, 1'b1);
        idle();
        check("sf_valid", 32'(out_valid), 32'h1);
        check("sf_data",  out_data,        32'h0000BBAA);
        check("sf_keep",  32'(out_keep),   32'h3);
        check("sf_last",  32'(out_last),   32'h1);
        tick();
        check("sf_drained", 32'(out_valid), 32'h0);

        // Backpressure: word A held, word B completes into the accumulator.
        out_ready = 1'b0;
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b0);
        beat(8'h03, 1'b0);
        beat(8'h04, 1'b0);
        check("bp_a_valid", 32'(out_valid), 32'h1);
        check("bp_a_data",  out_data,        32'h04030201);
        check("bp_a_last",  32'(out_last),   32'h0);
        beat(8'h05, 1'b0);
        beat(8'h06, 1'b0);
        beat(8'h07, 1'b0);
        check("bp_a_stable", out_data, 32'h04030201);
        beat(8'h08, 1'b1);
        idle();
        check("bp_pending_ready", 32'(in_ready), 32'h0);
        check("bp_a_held",        out_data,       32'h04030201);
        check("bp_a_keep_held",   32'(out_keep),  32'hF);
        tick();
        check("bp_still_blocked", 32'(in_ready),  32'h0);
        check("bp_still_valid",   32'(out_valid), 32'h1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_b_valid", 32'(out_valid), 32'h1);
        check("bp_b_data",  out_data,        32'h08070605);
        check("bp_b_keep",  32'(out_keep),   32'hF);
        check("bp_b_last",  32'(out_last),   32'h1);
        check("bp_b_ready", 32'(in_ready),   32'h1);
        tick();
        check("bp_b_hold", out_data, 32'h08070605);
        out_ready = 1'b1;
        tick();
        check("bp_drained", 32'(out_valid), 32'h0);

        // Completion coincides with the handshake of the previous word.
        out_ready = 1'b0;
        beat(8'h10, 1'b0);
        beat(8'h11, 1'b0);
        beat(8'h12, 1'b0);
        beat(8'h13, 1'b0);
        check("sc_w1_data", out_data, 32'h13121110);
        beat(8'h20, 1'b0);
        beat(8'h21, 1'b0);
        beat(8'h22, 1'b0);
        out_ready = 1'b1;
        beat(8'h23, 1'b1);
        idle();
        check("sc_w2_valid", 32'(out_valid), 32'h1);
        check("sc_w2_data",  out_data,        32'h23222120);
        check("sc_w2_last",  32'(out_last),   32'h1);
        check("sc_no_pend",  32'(in_ready),   32'h1);
        tick();
        check("sc_drained", 32'(out_valid), 32'h0);

        // Reset after two beats discards the partial word.
        beat(8'h31, 1'b0);
        beat(8'h32, 1'b0);
        idle();
        resetn = 1'b0;
        #1;
        check("mr_in_ready_low", 32'(in_ready), 32'h0);
        tick();
        check("mr_out_valid", 32'(out_valid), 32'h0);
        check("mr_out_keep",  32'(out_keep),  32'h0);
        resetn = 1'b1;
        beat(8'h41, 1'b1);
        idle();
        check("mr_valid", 32'(out_valid), 32'h1);
        check("mr_data",  out_data,        32'h00000041);
        check("mr_keep",  32'(out_keep),   32'h1);
        check("mr_last",  32'(out_last),   32'h1);
        tick();
        check("mr_drained", 32'(out_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
